// File: rtl/bist_misr_checker.sv
// BIST response compactor: serial-input MISR with bit counter and golden-signature check.
// The golden value is either the GOLDEN parameter or learned from the first clean session after reset.
module bist_misr_checker #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] POLY         = 16'h002D,
    parameter logic [WIDTH-1:0] SEED         = 16'h0000,
    parameter int               EXPECT_BITS  = 2000,
    parameter logic [WIDTH-1:0] GOLDEN       = 16'h0000,
    parameter bit               LEARN_GOLDEN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdo_valid,
    input  logic             cut_sdo,
    input  logic             finish,
    output logic             busy,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      bit_count,
    output logic             overflow,
    output logic             done,
    output logic             pass,
    output logic             golden_valid
);

    localparam logic [15:0] EXPECT_CNT = 16'(EXPECT_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPACT,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] golden;
    logic             count_full;
    logic             learn_now;

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                   input logic             din);
        logic [WIDTH-1:0] nxt;
        nxt = {sig[WIDTH-2:0], 1'b0};
        if (sig[WIDTH-1])
            nxt = nxt ^ POLY;
        nxt[0] = nxt[0] ^ din;
        return nxt;
    endfunction

    assign count_full = (bit_count == EXPECT_CNT);
    // Only a complete, clean session may become the reference signature.
    assign learn_now  = LEARN_GOLDEN && !golden_valid && count_full && !overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            signature    <= SEED;
            bit_count    <= 16'd0;
            overflow     <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            busy         <= 1'b0;
            golden       <= GOLDEN;
            golden_valid <= !LEARN_GOLDEN;
        end else if (start) begin
            state     <= ST_COMPACT;
            signature <= SEED;
            bit_count <= 16'd0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                ST_COMPACT: begin
                    if (sdo_valid) begin
                        if (count_full) begin
                            overflow <= 1'b1;
                        end else begin
                            signature <= misr_step(signature, cut_sdo);
                            bit_count <= bit_count + 16'd1;
                        end
                    end
                    if (finish)
                        state <= ST_COMPARE;
                end
                ST_COMPARE: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (learn_now) begin
                        golden       <= signature;
                        golden_valid <= 1'b1;
                        pass         <= 1'b1;
                    end else begin
                        pass <= golden_valid && (signature == golden) && count_full && !overflow;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_misr_checker.sv
// Scoreboard bench for bist_misr_checker: stimulus queues expectations, a negedge monitor checks them.
module tb_bist_misr_checker;

    localparam int          EXP_BITS = 2000;
    localparam logic [15:0] SEED_V   = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sdo_valid = 1'b0;
    logic        cut_sdo = 1'b0;
    logic        finish = 1'b0;
    logic        busy;
    logic [15:0] signature;
    logic [15:0] bit_count;
    logic        overflow;
    logic        done;
    logic        pass;
    logic        golden_valid;

    bist_misr_checker #(
        .WIDTH(16), .POLY(16'h002D), .SEED(SEED_V), .EXPECT_BITS(EXP_BITS),
        .GOLDEN(16'h0000), .LEARN_GOLDEN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sdo_valid(sdo_valid), .cut_sdo(cut_sdo),
        .finish(finish), .busy(busy), .signature(signature), .bit_count(bit_count),
        .overflow(overflow), .done(done), .pass(pass), .golden_valid(golden_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        bit          is_done;
        logic [15:0] sig;
        logic [15:0] cnt;
        logic        ovf;
        logic        pass;
        logic        gv;
        logic        done;
        logic        busy;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;
    logic probe = 1'b0;
    logic done_q = 1'b0;

    // Reference session state
    logic [15:0] m_sig;
    logic [15:0] m_cnt;
    logic        m_ovf;
    int          fin_cyc;

    // Polynomial-division form of the MISR: append the bit, reduce by x^16+x^5+x^3+x^2+1.
    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic b);
        logic [16:0] t;
        t = {s, b};
        if (t[16])
            t = t ^ 17'h1002D;
        return t[15:0];
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, req);
    endfunction

    // Monitor: pops one expectation per probe request or per rising edge of done.
    always @(negedge clk) begin
        exp_t e;
        if (probe || (done && !done_q)) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: done=%0b probe=%0b with empty scoreboard", done, probe);
            end else begin
                e = q.pop_front();
                chk({e.name, "_sig"},  32'(signature),    32'(e.sig));
                chk({e.name, "_cnt"},  32'(bit_count),    32'(e.cnt));
                chk({e.name, "_ovf"},  32'(overflow),     32'(e.ovf));
                chk({e.name, "_pass"}, 32'(pass),         32'(e.pass));
                chk({e.name, "_gv"},   32'(golden_valid), 32'(e.gv));
                chk({e.name, "_done"}, 32'(done),         32'(e.done));
                chk({e.name, "_busy"}, 32'(busy),         32'(e.busy));
                if (e.is_done)
                    chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
        done_q = done;
    end

    task automatic model_clear();
        m_sig = SEED_V;
        m_cnt = 16'd0;
        m_ovf = 1'b0;
    endtask

    task automatic model_bit(input logic b);
        if (m_cnt == 16'(EXP_BITS)) begin
            m_ovf = 1'b1;
        end else begin
            m_sig = ref_step(m_sig, b);
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
    endtask

    task automatic drive_bits(input int n, input logic [15:0] seed, input int flip, input bit fin_last);
        logic [15:0] l;
        logic        b;
        l = seed;
        for (int i = 0; i < n; i++) begin
            b = l[0] ^ (i == flip);
            sdo_valid = 1'b1;
            cut_sdo = b;
            model_bit(b);
            if (fin_last && i == n - 1) begin
                finish = 1'b1;
                fin_cyc = cyc;
            end
            l = lfsr_next(l);
            @(posedge clk); #1;
        end
        sdo_valid = 1'b0;
        cut_sdo = 1'b0;
        finish = 1'b0;
    endtask

    task automatic drive_const(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            sdo_valid = 1'b1;
            cut_sdo = b;
            model_bit(b);
            @(posedge clk); #1;
        end
        sdo_valid = 1'b0;
        cut_sdo = 1'b0;
    endtask

    task automatic push_probe(input string n, input logic [15:0] sig, input logic [15:0] cnt,
                              input logic ovf, input logic p, input logic gv,
                              input logic d, input logic bz);
        exp_t e;
        e = '{name: n, is_done: 1'b0, sig: sig, cnt: cnt, ovf: ovf, pass: p, gv: gv,
              done: d, busy: bz, cyc: 0};
        q.push_back(e);
        probe = 1'b1;
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic wait_drain(input string n, input int limit);
        int k;
        k = 0;
        while (q.size() != 0 && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        if (q.size() != 0) begin
            total++;
            $display("FAIL %s_timeout: %0d expectations pending, required 0", n, q.size());
            q.delete();
        end
    endtask

    // Expect done to rise two edges after the cycle in which finish was driven.
    task automatic expect_done(input string n, input logic p, input logic gv);
        exp_t e;
        e = '{name: n, is_done: 1'b1, sig: m_sig, cnt: m_cnt, ovf: m_ovf, pass: p, gv: gv,
              done: 1'b1, busy: 1'b0, cyc: fin_cyc + 2};
        q.push_back(e);
        wait_drain(n, 10);
    endtask

    task automatic do_finish();
        finish = 1'b1;
        fin_cyc = cyc;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        push_probe("reset", 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: single one then zeros walks to the MSB, then folds in the polynomial
        do_start();
        drive_const(1, 1'b1);
        drive_const(15, 1'b0);
        push_probe("t1_8000", 16'h8000, 16'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_const(1, 1'b0);
        push_probe("t1_002d", 16'h002D, 16'd17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // 2: learning session, finish ignored in DONE, identical replay passes
        do_start();
        drive_bits(EXP_BITS, 16'hACE1, -1, 1'b0);
        do_finish();
        expect_done("t2_learn", 1'b1, 1'b1);
        do_finish();
        push_probe("t2_fin_in_done", m_sig, m_cnt, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        do_start();
        drive_bits(EXP_BITS, 16'hACE1, -1, 1'b0);
        do_finish();
        expect_done("t2_replay", 1'b1, 1'b1);

        // 3: one corrupted bit
        do_start();
        drive_bits(EXP_BITS, 16'hACE1, 1000, 1'b0);
        do_finish();
        expect_done("t3_flip", 1'b0, 1'b1);

        // 4: short and overlong sessions
        do_start();
        drive_bits(EXP_BITS - 1, 16'hACE1, -1, 1'b0);
        do_finish();
        expect_done("t4_short", 1'b0, 1'b1);
        do_start();
        drive_bits(EXP_BITS + 1, 16'hACE1, -1, 1'b0);
        do_finish();
        expect_done("t4_over", 1'b0, 1'b1);

        // 5: reset mid-session drops the golden; the next clean session learns a new one
        do_start();
        drive_bits(500, 16'hACE1, -1, 1'b0);
        #2 rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        push_probe("t5_reset", 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        do_start();
        drive_bits(EXP_BITS, 16'h1234, -1, 1'b0);
        do_finish();
        expect_done("t5_relearn", 1'b1, 1'b1);

        // 6: last bit together with finish, then start together with finish
        do_start();
        drive_bits(EXP_BITS, 16'h1234, -1, 1'b1);
        expect_done("t6_last_fin", 1'b1, 1'b1);
        do_start();
        drive_bits(20, 16'h1234, -1, 1'b0);
        start = 1'b1;
        finish = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish = 1'b0;
        model_clear();
        push_probe("t6_start_fin", 16'h0000, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        push_probe("t6_still_compact", 16'h0000, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        wait_drain("final", 10);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
